// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin arbiter/sequencer sharing one key/value
// cache between NUM_REQ requesters, one transaction in flight at a time.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req_valid_i/ready_o per-requester request handshake (ready one-hot)
//   req_op/key/value_i  packed per-requester request fields
//   rsp_valid_o/ready_i per-requester response handshake (valid one-hot)
//   rsp_hit/err/value_o shared response payload
//   cache_*             command port and completion inputs of the cache
//   busy_o              high whenever not idle
//   grant_idx_o         current or last granted requester

package cache_cfg_pkg;
    localparam int KEY_WIDTH   = 16;
    localparam int VALUE_WIDTH = 16;
endpackage

module cache_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int KEY_WIDTH      = cache_cfg_pkg::KEY_WIDTH,
    parameter int VALUE_WIDTH    = cache_cfg_pkg::VALUE_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IW            = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [2*NUM_REQ-1:0]           req_op_i,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key_i,
    input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic                           rsp_hit_o,
    output logic                           rsp_err_o,
    output logic [VALUE_WIDTH-1:0]         rsp_value_o,
    output logic                           cache_valid_o,
    input  logic                           cache_ready_i,
    output logic [1:0]                     cache_op_o,
    output logic [KEY_WIDTH-1:0]           cache_key_o,
    output logic [VALUE_WIDTH-1:0]         cache_value_o,
    input  logic                           cache_done_i,
    input  logic                           cache_hit_i,
    input  logic [VALUE_WIDTH-1:0]         cache_value_i,
    output logic                           busy_o,
    output logic [IW-1:0]                  grant_idx_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] OP_GET = 2'b01;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [15:0]      cnt;

    logic             win_found;
    logic [IW-1:0]    win_idx;
    int               j;
    logic             hs;
    logic [1:0]       sel_op;
    logic [KEY_WIDTH-1:0]   sel_key;
    logic [VALUE_WIDTH-1:0] sel_value;

    // First valid requester at or above ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_found && req_valid_i[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

    // Ready is combinational, gated so it stays low during reset.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && !rst && win_found)
            req_ready_o[win_idx] = 1'b1;
    end

    assign hs        = |req_ready_o;
    assign sel_op    = req_op_i[2*int'(win_idx) +: 2];
    assign sel_key   = req_key_i[KEY_WIDTH*int'(win_idx) +: KEY_WIDTH];
    assign sel_value = req_value_i[VALUE_WIDTH*int'(win_idx) +: VALUE_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            grant_idx_o   <= '0;
            rsp_valid_o   <= '0;
            rsp_hit_o     <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_value_o   <= '0;
            cache_valid_o <= 1'b0;
            cache_op_o    <= '0;
            cache_key_o   <= '0;
            cache_value_o <= '0;
            busy_o        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        grant_idx_o   <= win_idx;
                        cache_op_o    <= sel_op;
                        cache_key_o   <= sel_key;
                        cache_value_o <= sel_value;
                        busy_o        <= 1'b1;
                        if (sel_op == 2'b00) begin
                            // Illegal op answers directly, no cache access.
                            rsp_valid_o <= ONE << win_idx;
                            rsp_err_o   <= 1'b1;
                            rsp_hit_o   <= 1'b0;
                            rsp_value_o <= '0;
                            state       <= RESP;
                        end else begin
                            cache_valid_o <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cache_ready_i) begin
                        cache_valid_o <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // Done has priority over a coincident timeout.
                    if (cache_done_i) begin
                        rsp_valid_o <= ONE << grant_idx_o;
                        rsp_hit_o   <= cache_hit_i;
                        rsp_err_o   <= 1'b0;
                        rsp_value_o <= (cache_op_o == OP_GET) ?
                                       cache_value_i : '0;
                        state       <= RESP;
                    end else if (cnt == 16'(TIMEOUT_CYCLES)) begin
                        rsp_valid_o <= ONE << grant_idx_o;
                        rsp_hit_o   <= 1'b0;
                        rsp_err_o   <= 1'b1;
                        rsp_value_o <= '0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i[grant_idx_o]) begin
                        rsp_valid_o <= '0;
                        rsp_hit_o   <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_value_o <= '0;
                        busy_o      <= 1'b0;
                        if (grant_idx_o == IW'(NUM_REQ-1))
                            ptr <= '0;
                        else
                            ptr <= grant_idx_o + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: randomized bench with a transaction-level
// round-robin and response model for cache_req_arbiter.

module tb_cache_req_arbiter;

    localparam int N  = 4;
    localparam int KW = cache_cfg_pkg::KEY_WIDTH;
    localparam int VW = cache_cfg_pkg::VALUE_WIDTH;
    localparam int T  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [2*N-1:0]    req_op_i;
    logic [KW*N-1:0]   req_key_i;
    logic [VW*N-1:0]   req_value_i;
    logic [N-1:0]      rsp_valid_o;
    logic [N-1:0]      rsp_ready_i;
    logic              rsp_hit_o;
    logic              rsp_err_o;
    logic [VW-1:0]     rsp_value_o;
    logic              cache_valid_o;
    logic              cache_ready_i;
    logic [1:0]        cache_op_o;
    logic [KW-1:0]     cache_key_o;
    logic [VW-1:0]     cache_value_o;
    logic              cache_done_i;
    logic              cache_hit_i;
    logic [VW-1:0]     cache_value_i;
    logic              busy_o;
    logic [IW-1:0]     grant_idx_o;

    cache_req_arbiter #(
        .NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_key_i(req_key_i),
        .req_value_i(req_value_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o),
        .rsp_value_o(rsp_value_o),
        .cache_valid_o(cache_valid_o), .cache_ready_i(cache_ready_i),
        .cache_op_o(cache_op_o), .cache_key_o(cache_key_o),
        .cache_value_o(cache_value_o),
        .cache_done_i(cache_done_i), .cache_hit_i(cache_hit_i),
        .cache_value_i(cache_value_i),
        .busy_o(busy_o), .grant_idx_o(grant_idx_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int mptr  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[(mptr + i) % N]) return (mptr + i) % N;
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},  req_ready_o, 0);
        chk({tag, "_rv"},   rsp_valid_o, 0);
        chk({tag, "_hit"},  rsp_hit_o, 0);
        chk({tag, "_err"},  rsp_err_o, 0);
        chk({tag, "_rval"}, rsp_value_o, 0);
        chk({tag, "_cv"},   cache_valid_o, 0);
        chk({tag, "_cop"},  cache_op_o, 0);
        chk({tag, "_ckey"}, cache_key_o, 0);
        chk({tag, "_cval"}, cache_value_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_gnt"},  grant_idx_o, 0);
    endtask

    // One complete transaction. done_at > T means the cache never answers.
    task automatic run_txn(input logic [N-1:0] mask, input int op_sel,
                           input int rdly, input int done_at,
                           input int rspdly, input bit rst_mid,
                           output int granted);
        logic [1:0]    ops [N];
        logic [KW-1:0] keys[N];
        logic [VW-1:0] vals[N];
        logic [1:0]    op;
        logic [N-1:0]  oh;
        logic          ex_hit, ex_err, dh, fin;
        logic [VW-1:0] ex_val, dv;
        int            w, c;
        ex_hit = 0; ex_err = 0; ex_val = '0; dh = 0; dv = '0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ops[i]  = 2'($urandom);
            keys[i] = KW'($urandom);
            vals[i] = VW'($urandom);
            if (op_sel >= 0) ops[i] = op_sel[1:0];
            req_op_i[2*i +: 2]     = ops[i];
            req_key_i[KW*i +: KW]  = keys[i];
            req_value_i[VW*i +: VW] = vals[i];
        end
        req_valid_i   = mask;
        rsp_ready_i   = '0;
        cache_ready_i = 0;
        cache_done_i  = 0;
        w       = pick(mask);
        granted = w;
        oh      = N'(1) << w;
        op      = ops[w];
        #1;
        chk("ready", req_ready_o, oh);
        chk("busy_idle", busy_o, 0);
        @(negedge clk);
        // Inputs are only sampled at the handshake; scramble them now.
        req_op_i    = 8'($urandom);
        req_key_i   = {N*KW/32+1{$urandom}};
        req_value_i = {N*VW/32+1{$urandom}};
        req_valid_i = N'($urandom);
        #1;
        chk("ready_busy", req_ready_o, 0);
        chk("grant", grant_idx_o, w);
        chk("busy", busy_o, 1);
        if (op == 2'b00) begin
            ex_err = 1;
            chk("illegal_cv", cache_valid_o, 0);
        end else begin
            for (int d = 0; d <= rdly; d++) begin
                chk("cvalid", cache_valid_o, 1);
                chk("cop", cache_op_o, op);
                chk("ckey", cache_key_o, keys[w]);
                chk("cval", cache_value_o, vals[w]);
                chk("issue_rv", rsp_valid_o, 0);
                cache_ready_i = (d == rdly);
                cache_done_i  = 1'($urandom);
                @(negedge clk);
                #1;
            end
            cache_ready_i = 0;
            cache_done_i  = 0;
            chk("cv_drop", cache_valid_o, 0);
            fin = 0;
            c = 0;
            while (!fin && c <= T) begin
                if (rst_mid && c == 1) begin
                    req_valid_i = mask;
                    rst = 1;
                    #1;
                    chk_all_zero("rst_wait");
                    @(negedge clk);
                    rst = 0;
                    req_valid_i = '0;
                    mptr = 0;
                    #1;
                    chk("rst_rel_rv", rsp_valid_o, 0);
                    chk("rst_rel_busy", busy_o, 0);
                    return;
                end
                cache_hit_i   = 1'($urandom);
                cache_value_i = VW'($urandom);
                cache_done_i  = (c == done_at);
                dh = cache_hit_i;
                dv = cache_value_i;
                @(negedge clk);
                cache_done_i = 0;
                #1;
                if (c == done_at) begin
                    ex_err = 0;
                    ex_hit = dh;
                    ex_val = (op == 2'b01) ? dv : '0;
                    fin = 1;
                end else if (c == T) begin
                    ex_err = 1;
                    fin = 1;
                end else begin
                    chk("wait_rv", rsp_valid_o, 0);
                end
                c++;
            end
            if (!fin) chk("wait_bound", 0, 1);
        end
        chk("rsp_valid", rsp_valid_o, oh);
        chk("rsp_hit", rsp_hit_o, ex_hit);
        chk("rsp_err", rsp_err_o, ex_err);
        chk("rsp_value", rsp_value_o, ex_val);
        for (int b = 0; b < rspdly; b++) begin
            rsp_ready_i  = N'($urandom) & ~oh;
            cache_done_i = 1'($urandom);
            cache_hit_i  = 1'($urandom);
            req_valid_i  = N'($urandom) | N'(1);
            @(negedge clk);
            #1;
            chk("bp_rv", rsp_valid_o, oh);
            chk("bp_hit", rsp_hit_o, ex_hit);
            chk("bp_err", rsp_err_o, ex_err);
            chk("bp_val", rsp_value_o, ex_val);
            chk("bp_rdy", req_ready_o, 0);
        end
        rsp_ready_i  = oh | N'($urandom);
        cache_done_i = 0;
        req_valid_i  = '0;
        @(negedge clk);
        rsp_ready_i = '0;
        #1;
        chk("rsp_clear", rsp_valid_o, 0);
        chk("idle_busy", busy_o, 0);
        mptr = (w + 1) % N;
    endtask

    int g;
    int rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1;
        req_valid_i = '1;
        req_op_i = '0; req_key_i = '0; req_value_i = '0;
        rsp_ready_i = '0; cache_ready_i = 0; cache_done_i = 0;
        cache_hit_i = 0; cache_value_i = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 0;
        req_valid_i = '0;

        for (int i = 0; i < 5; i++) begin
            run_txn(4'hF, 2, 0, 0, 0, 0, g);
            chk("rr_order", g, rr_exp[i]);
        end
        run_txn(4'b0100, 1, 0, 0, 0, 0, g);
        chk("get_r2", g, 2);
        run_txn(4'b0001, 1, 1, 99, 0, 0, g);
        run_txn(4'b0001, 1, 0, T, 0, 0, g);
        run_txn(4'b0010, 0, 0, 0, 1, 0, g);
        chk("illegal_r1", g, 1);
        run_txn(4'b1000, 3, 0, 1, 10, 0, g);
        chk("bp_r3", g, 3);
        run_txn(4'b0010, 1, 0, 3, 0, 1, g);
        run_txn(4'hF, 2, 0, 0, 0, 0, g);
        chk("after_rst", g, 0);

        for (int k = 0; k < 300; k++) begin
            run_txn(N'($urandom_range(1, (1 << N) - 1)), -1,
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, T + 2)),
                    int'($urandom_range(0, 3)), 0, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Round-robin arbiter and sequencer that shares the single key/value cache (controller plus memory block) between `NUM_REQ` independent requesters. It accepts one GET/PUT/DEL at a time over a per-requester valid/ready port, drives the cache command port, waits for completion or timeout, and routes the hit/value/error result back to the originating requester. It sits between the requester-side bus adapters and the cache core.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `KEY_WIDTH`, `cache_cfg_pkg::KEY_WIDTH`: key width.
- `VALUE_WIDTH`, `cache_cfg_pkg::VALUE_WIDTH`: value width.
- `TIMEOUT_CYCLES`, 255: maximum number of WAIT cycles before an error response, 1..65535.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  NUM_REQ  request valid, one bit per requester.
- `req_ready_o`  out  NUM_REQ  request accepted, one-hot or zero.
- `req_op_i`  in  2*NUM_REQ  op per requester: 01 GET, 10 PUT, 11 DEL, 00 illegal.
- `req_key_i`  in  KEY_WIDTH*NUM_REQ  key per requester.
- `req_value_i`  in  VALUE_WIDTH*NUM_REQ  PUT data per requester.
- `rsp_valid_o`  out  NUM_REQ  response valid, one-hot or zero.
- `rsp_ready_i`  in  NUM_REQ  response taken.
- `rsp_hit_o`  out  1  shared; key found (GET/DEL) or stored (PUT).
- `rsp_err_o`  out  1  shared; timeout or illegal op.
- `rsp_value_o`  out  VALUE_WIDTH  shared; GET data, otherwise 0.
- `cache_valid_o`  out  1  command valid to cache.
- `cache_ready_i`  in  1  cache accepts command.
- `cache_op_o`  out  2  latched op.
- `cache_key_o`  out  KEY_WIDTH  latched key.
- `cache_value_o`  out  VALUE_WIDTH  latched value.
- `cache_done_i`  in  1  single-cycle completion pulse.
- `cache_hit_i`  in  1  hit, qualified by `cache_done_i`.
- `cache_value_i`  in  VALUE_WIDTH  read data, qualified by `cache_done_i`.
- `busy_o`  out  1  state != IDLE.
- `grant_idx_o`  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Round-robin pointer `ptr` starts at 0. In IDLE the winner is the first asserted `req_valid_i` bit found by searching upward from `ptr` with wrap-around.
- `req_ready_o[winner]` is driven combinationally in IDLE only. It depends on `req_valid_i`; ready never asserts without valid.
- On the request handshake:
  - Latch op, key, value and winner into `grant_idx_o`.
  - If op = 00, go to RESP with err=1, hit=0, value=0. No cache access occurs.
  - Otherwise go to ISSUE.
- ISSUE:
  - `cache_valid_o`=1, with `cache_op_o`/`cache_key_o`/`cache_value_o` held stable.
  - On `cache_ready_i`, go to WAIT and clear the timeout counter.
- WAIT:
  - The counter increments every cycle.
  - On `cache_done_i`, capture hit and value (value forced to 0 unless op = GET), set err=0, go to RESP.
  - When the counter reaches `TIMEOUT_CYCLES` with no done, set err=1, hit=0, value=0, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `rsp_valid_o[grant_idx_o]`=1 with `rsp_*` held stable.
  - On `rsp_ready_i[grant_idx_o]`, set `ptr` = (grant+1) mod NUM_REQ and go to IDLE.
  - `rsp_ready_i` bits of other requesters are ignored.
- `cache_done_i` outside WAIT is ignored, including a done in the same cycle as the ISSUE handshake.
- Request inputs of non-granted requesters may change freely. Inputs of the granted requester are sampled only at the handshake.

## Timing
- Reset (async assert): state IDLE, `ptr` 0, and every output 0. That covers `grant_idx_o` and all `rsp_*`/`cache_*` outputs, and makes `req_ready_o` 0 while reset is asserted.
- Reset mid-operation aborts the transaction. No response is issued; the cache command is simply dropped.
- Minimum latency, with `cache_ready_i` and `cache_done_i` both high at the earliest opportunity:
  - Request handshake at cycle 0.
  - `cache_valid_o` at cycle 1.
  - WAIT at cycle 2, done sampled there.
  - `rsp_valid_o` at cycle 3.
  - Back in IDLE at cycle 4 if `rsp_ready_i` was high in cycle 3.
- Illegal op: handshake at cycle 0, `rsp_valid_o` at cycle 1.
- Timeout: `rsp_valid_o` asserts `TIMEOUT_CYCLES`+1 cycles after entering WAIT.
- Exactly one transaction is in flight; there is no pipelining. Back-to-back throughput is one op per 4 cycles minimum.

## Test plan
- Single GET from requester 2: `cache_ready_i`=1, done at first WAIT cycle with hit=1, value=0xDEAD. Required: `cache_op_o`=01 with the latched key, then `rsp_valid_o`=0b0100, hit=1, value=0xDEAD, err=0, 3 cycles after the handshake.
- All 4 requesters hold valid continuously, PUT each, instant cache. Required: grant order 0,1,2,3,0 and `ptr` wrap after index 3.
- Cache never asserts done, `TIMEOUT_CYCLES`=4. Required: response err=1, hit=0, value=0 exactly 5 cycles after WAIT entry. Done and timeout in the same cycle yields err=0.
- Illegal op 00 from requester 1. Required: no `cache_valid_o`, response err=1 on the cycle after the handshake.
- Response backpressure: hold `rsp_ready_i`=0 for 10 cycles while requester 3 is valid. Required: `rsp_*` stable, `req_ready_o`=0 throughout. A stray done pulse in RESP has no effect.
- Assert `rst` in WAIT. Required: all outputs 0 immediately; after release, IDLE with `ptr`=0 and no response to the aborted requester.
